i2c_master_write_ctrl: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_tx_shifter.sv | 21 ++
 rtl/i2c_master_write_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2c_master_write_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master write path: writer command codes and
// the write-controller state encoding.
package i2c_pkg;

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_BYTE  = 3'b011;
  localparam logic [2:0] CMD_STOP  = 3'b100;
  localparam logic [2:0] CMD_ACK   = 3'b111;
  localparam logic [2:0] CMD_NACK  = 3'b101;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_FETCH,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP,
    ST_DONE,
    ST_WAIT_REL
  } ctrl_state_t;

endpackage

// File: rtl/i2c_tx_shifter.sv
// 8-bit parallel-load, left-shift register feeding the byte writer MSB first.
module i2c_tx_shifter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_en,
  input  logic       shift_en,
  input  logic [7:0] load_data,
  output logic       serial_out
);

  logic [7:0] shreg;

  always_ff @(posedge clock) begin
    if (reset)         shreg <= '0;
    else if (load_en)  shreg <= load_data;
    else if (shift_en) shreg <= {shreg[6:0], 1'b0};
  end

  assign serial_out = shreg[7];

endmodule

// File: rtl/i2c_master_write_ctrl.sv
// Write-transaction sequencer: START, address+W, data bytes, STOP over the byte
// writer's go/finish handshake. Define I2C_CTRL_ACK_CHECK_EN to abort on NACK.
//
// state       | meaning
// ST_IDLE     | waiting for start_req
// ST_START    | writer issuing START
// ST_ADDR     | writer shifting address+W byte
// ST_ADDR_ACK | ACK slot after the address
// ST_FETCH    | waiting for the next data byte from the host
// ST_DATA     | writer shifting a data byte
// ST_DATA_ACK | ACK slot after a data byte
// ST_STOP     | writer issuing STOP
// ST_DONE     | one-cycle completion
// ST_WAIT_REL | waiting for finish to drop before moving to resume state
module i2c_master_write_ctrl
  import i2c_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start_req,
  input  logic [6:0] slave_addr,
  input  logic [3:0] byte_count,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       wb_go,
  output logic [2:0] wb_command,
  output logic       wb_data,
  input  logic       wb_load,
  input  logic       wb_finish,
  output logic       ack_go,
  input  logic       ack_finish,
  input  logic       ack_bit
);

  ctrl_state_t state, state_nxt, resume, resume_nxt;
  logic [3:0]  remaining;
  logic        accept, fetch_xfer, nack_seen, in_ack;
  logic        load_en, shift_en;
  logic [7:0]  load_data;

  assign accept     = (state == ST_IDLE) && start_req;
  assign fetch_xfer = (state == ST_FETCH) && wr_valid;
  assign in_ack     = (state == ST_ADDR_ACK) || (state == ST_DATA_ACK);

`ifdef I2C_CTRL_ACK_CHECK_EN
  assign nack_seen = ack_finish & ack_bit;

  always_ff @(posedge clock) begin
    if (reset)                     nack_err <= 1'b0;
    else if (accept)               nack_err <= 1'b0;
    else if (in_ack && nack_seen)  nack_err <= 1'b1;
  end
`else
  logic unused_ack_bit;
  assign unused_ack_bit = ack_bit;
  assign nack_seen      = 1'b0;
  assign nack_err       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      resume <= ST_IDLE;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)           remaining <= '0;
    else if (accept)     remaining <= byte_count;
    else if (fetch_xfer) remaining <= remaining - 4'd1;
  end

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    unique case (state)
      ST_IDLE:  if (start_req) state_nxt = ST_START;
      ST_START: if (wb_finish) begin
        state_nxt  = ST_WAIT_REL;
        resume_nxt = ST_ADDR;
      end
      ST_ADDR:  if (wb_finish) begin
        state_nxt  = ST_WAIT_REL;
        resume_nxt = ST_ADDR_ACK;
      end
      ST_ADDR_ACK, ST_DATA_ACK: if (ack_finish) begin
        state_nxt  = ST_WAIT_REL;
        resume_nxt = (nack_seen || remaining == 4'd0) ? ST_STOP : ST_FETCH;
      end
      ST_FETCH: if (wr_valid) state_nxt = ST_DATA;
      ST_DATA:  if (wb_finish) begin
        state_nxt  = ST_WAIT_REL;
        resume_nxt = ST_DATA_ACK;
      end
      ST_STOP:  if (wb_finish) begin
        state_nxt  = ST_WAIT_REL;
        resume_nxt = ST_DONE;
      end
      ST_DONE:     state_nxt = ST_IDLE;
      ST_WAIT_REL: if (!wb_finish && !ack_finish) state_nxt = resume;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE) && (state != ST_DONE);
    done       = (state == ST_DONE);
    wr_ready   = fetch_xfer;
    ack_go     = in_ack;
    wb_go      = 1'b0;
    wb_command = 3'b000;
    unique case (state)
      ST_START: begin
        wb_go      = 1'b1;
        wb_command = CMD_START;
      end
      ST_ADDR, ST_DATA: begin
        wb_go      = 1'b1;
        wb_command = CMD_BYTE;
      end
      ST_STOP: begin
        wb_go      = 1'b1;
        wb_command = CMD_STOP;
      end
      default: ;
    endcase
  end

  // Address is loaded at accept so it is already on wb_data when ADDR starts.
  assign load_en   = accept || fetch_xfer;
  assign load_data = accept ? {slave_addr, 1'b0} : wr_data;
  assign shift_en  = wb_load && ((state == ST_ADDR) || (state == ST_DATA));

  i2c_tx_shifter u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load_en    (load_en),
    .shift_en   (shift_en),
    .load_data  (load_data),
    .serial_out (wb_data)
  );

endmodule

// File: tb/tb_i2c_master_write_ctrl.sv
// Directed bench for i2c_master_write_ctrl with writer / ACK-slot responders.
module tb_i2c_master_write_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_req = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [3:0] byte_count = '0;
  logic [7:0] wr_data;
  logic       wr_valid = 1'b0;
  logic       wr_ready, busy, done, nack_err, wb_go, wb_data, ack_go;
  logic [2:0] wb_command;
  logic       wb_load = 1'b0;
  logic       wb_finish = 1'b0;
  logic       ack_finish = 1'b0;
  logic       ack_bit = 1'b0;

  int checks = 0;
  int errors = 0;

  i2c_master_write_ctrl dut (
    .clock(clock), .reset(reset), .start_req(start_req), .slave_addr(slave_addr),
    .byte_count(byte_count), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .nack_err(nack_err), .wb_go(wb_go), .wb_command(wb_command),
    .wb_data(wb_data), .wb_load(wb_load), .wb_finish(wb_finish), .ack_go(ack_go),
    .ack_finish(ack_finish), .ack_bit(ack_bit)
  );

  always #5 clock = ~clock;

  // Byte writer responder: logs {command, serial byte} per completed command.
  logic [10:0] wlog[$];
  int          w_st = 0, w_cnt = 0, hs_viol = 0, gap_viol = 0;
  logic [2:0]  w_cmd = '0;
  logic [7:0]  w_bits = '0;
  bit          rel_pend = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      w_st = 0; wb_load = 1'b0; wb_finish = 1'b0; rel_pend = 1'b0;
    end else begin
      case (w_st)
        0: begin
          if (rel_pend) begin
            if (!(wb_go || ack_go)) gap_viol++;
            rel_pend = 1'b0;
          end
          if (wb_go && !wb_finish) begin
            w_cmd  = wb_command;
            w_bits = '0;
            if (wb_command == 3'b011) begin
              w_bits = {w_bits[6:0], wb_data};
              w_cnt = 1; wb_load = 1'b1; w_st = 1;
            end else begin
              wb_finish = 1'b1; w_st = 2;
            end
          end
        end
        1: begin
          if (w_cnt == 8) begin
            wb_load = 1'b0; wb_finish = 1'b1; w_st = 2;
          end else begin
            w_bits = {w_bits[6:0], wb_data};
            w_cnt++;
          end
        end
        2: begin
          if (!wb_go) begin
            wb_finish = 1'b0;
            wlog.push_back({w_cmd, w_bits});
            rel_pend = (w_cmd != 3'b100);
            w_st = 0;
          end else hs_viol++;
        end
        default: w_st = 0;
      endcase
    end
  end

  // ACK-slot responder: NACKs the slot whose absolute index equals nack_at.
  int a_st = 0, a_cnt = 0, ack_viol = 0, nack_at = -1;

  always @(negedge clock) begin
    if (reset) begin
      a_st = 0; ack_finish = 1'b0; ack_bit = 1'b0;
    end else if (a_st == 0) begin
      if (ack_go && !ack_finish) begin
        ack_bit = (a_cnt == nack_at); ack_finish = 1'b1; a_cnt++; a_st = 1;
      end
    end else begin
      if (!ack_go) begin
        ack_finish = 1'b0; ack_bit = 1'b0; a_st = 0;
      end else ack_viol++;
    end
  end

  // Host data source and output monitors.
  logic [7:0] tx_data [16];
  int  xfer_total = 0, data_base = 0, rdy_hi = 0, done_cnt = 0;
  bit  xfer_pend = 1'b0;

  assign wr_data = tx_data[4'(xfer_total - data_base)];

  always @(negedge clock) begin
    if (xfer_pend) xfer_total++;
    xfer_pend = wr_valid && wr_ready;
    if (wr_ready) rdy_hi++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [10:0] exp_q[$];
  int log_base = 0;

  task automatic check_log(input string tag);
    logic [10:0] o;
    check({tag, "_len"}, wlog.size() - log_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (log_base + i < wlog.size()) ? wlog[log_base + i] : 11'h7ff;
      check($sformatf("%s_ent%0d", tag, i), o, exp_q[i]);
    end
  endtask

  task automatic begin_txn(input logic [6:0] addr, input logic [3:0] cnt);
    log_base  = wlog.size();
    data_base = xfer_total;
    exp_q.delete();
    tick();
    slave_addr = addr; byte_count = cnt; start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start_cnt);
    int n = 0;
    while (done_cnt == start_cnt && n < 800) begin tick(); n++; end
    check({tag, "_done_seen"}, done_cnt != start_cnt, 1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_nack"}, nack_err, 0);
    check({tag, "_go"},   wb_go, 0);
    check({tag, "_ackgo"}, ack_go, 0);
    check({tag, "_rdy"},  wr_ready, 0);
    check({tag, "_cmd"},  wb_command, 3'b000);
    check({tag, "_data"}, wb_data, 0);
  endtask

  int d0, r0, x0, a0, n;
  bit stall_bad;

  initial begin
    for (int i = 0; i < 16; i++) tx_data[i] = 8'h00;
    tick(); tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // T1: addr 50, two bytes, all ACK
    tx_data[0] = 8'hAC; tx_data[1] = 8'h35; wr_valid = 1'b1;
    d0 = done_cnt; r0 = rdy_hi; a0 = a_cnt;
    begin_txn(7'h50, 4'd2);
    check("t1_go_after_accept", wb_go, 1);
    check("t1_cmd_start", wb_command, 3'b001);
    check("t1_busy", busy, 1);
    wait_done("t1", d0);
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'hA0});
    exp_q.push_back({3'b011, 8'hAC}); exp_q.push_back({3'b011, 8'h35});
    exp_q.push_back({3'b100, 8'h00});
    check_log("t1");
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_nack", nack_err, 0);
    check("t1_busy_end", busy, 0);
    check("t1_rdy_cycles", rdy_hi - r0, 2);
    check("t1_ack_slots", a_cnt - a0, 3);

    // T2: zero-byte write, wr_valid high but never consumed
    d0 = done_cnt; r0 = rdy_hi; a0 = a_cnt;
    begin_txn(7'h1F, 4'd0);
    wait_done("t2", d0);
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'h3E});
    exp_q.push_back({3'b100, 8'h00});
    check_log("t2");
    check("t2_rdy_cycles", rdy_hi - r0, 0);
    check("t2_ack_slots", a_cnt - a0, 1);

    // T3: host stalls 20 cycles in FETCH
    wr_valid = 1'b0; tx_data[0] = 8'h5A;
    d0 = done_cnt; r0 = rdy_hi; a0 = a_cnt;
    begin_txn(7'h22, 4'd1);
    n = 0;
    while (!(a_cnt == a0 + 1 && a_st == 0) && n < 200) begin tick(); n++; end
    check("t3_addr_ack_seen", a_cnt - a0, 1);
    tick(); tick();
    stall_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_go || wr_ready || !busy) stall_bad = 1'b1;
      tick();
    end
    check("t3_stall_quiet", stall_bad, 0);
    wr_valid = 1'b1;
    tick();
    check("t3_resume_go", wb_go, 1);
    check("t3_resume_cmd", wb_command, 3'b011);
    wr_valid = 1'b0;
    wait_done("t3", d0);
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'h44});
    exp_q.push_back({3'b011, 8'h5A}); exp_q.push_back({3'b100, 8'h00});
    check_log("t3");
    check("t3_rdy_cycles", rdy_hi - r0, 1);

    // T4: NACK on the address byte
    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33; wr_valid = 1'b1;
    d0 = done_cnt; r0 = rdy_hi; a0 = a_cnt; nack_at = a_cnt;
    begin_txn(7'h48, 4'd3);
    wait_done("t4", d0);
    nack_at = -1;
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'h90});
`ifdef I2C_CTRL_ACK_CHECK_EN
    exp_q.push_back({3'b100, 8'h00});
    check_log("t4");
    check("t4_nack_err", nack_err, 1);
    check("t4_rdy_cycles", rdy_hi - r0, 0);
    check("t4_ack_slots", a_cnt - a0, 1);
`else
    exp_q.push_back({3'b011, 8'h11}); exp_q.push_back({3'b011, 8'h22});
    exp_q.push_back({3'b011, 8'h33}); exp_q.push_back({3'b100, 8'h00});
    check_log("t4");
    check("t4_nack_err", nack_err, 0);
    check("t4_rdy_cycles", rdy_hi - r0, 3);
    check("t4_ack_slots", a_cnt - a0, 4);
`endif

    // T5: start_req while busy is ignored; nack_err cleared on accept
    tx_data[0] = 8'h0F;
    d0 = done_cnt;
    begin_txn(7'h33, 4'd1);
    check("t5_nack_cleared", nack_err, 0);
    for (int i = 0; i < 10; i++) tick();
    slave_addr = 7'h7F; byte_count = 4'd5; start_req = 1'b1;
    tick();
    start_req = 1'b0;
    wait_done("t5", d0);
    for (int i = 0; i < 10; i++) tick();
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'h66});
    exp_q.push_back({3'b011, 8'h0F}); exp_q.push_back({3'b100, 8'h00});
    check_log("t5");
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_idle_busy", busy, 0);

    // T6: reset while a data byte is being shifted
    tx_data[0] = 8'hF0; tx_data[1] = 8'h0F;
    a0 = a_cnt;
    begin_txn(7'h0A, 4'd2);
    n = 0;
    while (!(w_st == 1 && w_cmd == 3'b011 && a_cnt == a0 + 1) && n < 200) begin tick(); n++; end
    check("t6_in_data", a_cnt - a0, 1);
    check("t6_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check_idle_outputs("t6_rst");
    tick();
    reset = 1'b0;
    tick();
    check("t6_stays_idle", busy, 0);

    // T7: clean transaction after the mid-flight reset
    d0 = done_cnt;
    begin_txn(7'h01, 4'd0);
    wait_done("t7", d0);
    exp_q.push_back({3'b001, 8'h00}); exp_q.push_back({3'b011, 8'h02});
    exp_q.push_back({3'b100, 8'h00});
    check_log("t7");

    check("wb_handshake", hs_viol, 0);
    check("wb_next_go_gap", gap_viol, 0);
    check("ack_handshake", ack_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
